// File: rtl/render_queue.sv
// render_queue: CPU-fed (Avalon-MM) circular queue of 48-bit render
// instructions. The display engine reads the head combinationally and
// pops it. A sentinel is shown whenever the queue is empty.
module render_queue #(
  parameter int DEPTH = 25,
  parameter int CW    = 5
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [47:0] SENTINEL = 48'hFF00_0000_0000;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    magic_q, magic_d, flags_q, flags_d;
  logic [15:0]   x_q, x_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          wr_en, rd_en, empty, full;
  logic          push_req, push_ok, pop_ok;
  logic [4:0]    cnt5;
  logic [15:0]   status;
  logic [47:0]   entry;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of 2).
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_ok   = render_queue_pop_front & ~empty;
  assign push_req = wr_en & (address == 2'd2);
  // A push into a full queue still fits if the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop_ok);
  // y goes straight from writedata into the entry, so it is never staged.
  assign entry    = {magic_q, x_q, writedata, flags_q};
  assign cnt5     = 5'(count_q);
  assign status   = {8'h00, ovf_q, empty, full, cnt5};

  assign render_queue_dout = empty ? SENTINEL : mem[head_q];
  assign readdata          = rdata_q;

  // Next-state for pointers, count, overflow flag, staging and readback.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    magic_d = magic_q;
    flags_d = flags_q;
    x_d     = x_q;
    rdata_d = '0;

    if (pop_ok)  head_d = nxt(head_q);
    if (push_ok) tail_d = nxt(tail_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_en) begin
      case (address)
        2'd0: begin magic_d = writedata[15:8]; flags_d = writedata[7:0]; end
        2'd1: x_d = writedata;
        default: ;
      endcase
    end

    // Clear wins over a same-cycle set.
    if (push_req && full && !pop_ok) ovf_d = 1'b1;
    if (wr_en && address == 2'd3)    ovf_d = 1'b0;

    if (rd_en && address == 2'd3) rdata_d = status;
  end

  // State registers with synchronous reset; reset masks all requests.
  always_ff @(posedge clk50) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      magic_q <= '0;
      flags_q <= '0;
      x_q     <= '0;
      rdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      magic_q <= magic_d;
      flags_q <= flags_d;
      x_q     <= x_d;
      rdata_q <= rdata_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk50) begin
    if (!reset && push_ok) mem[tail_q] <= entry;
  end

endmodule

// File: tb/tb_render_queue.sv
// Scoreboard bench for render_queue: expected entries are queued on each
// push and compared against the head when the engine pops.
module tb_render_queue;
  localparam int          DEPTH = 25;
  localparam logic [47:0] SENT  = 48'hFF00_0000_0000;

  logic        clk50 = 1'b0;
  logic        reset, cs, wr, rd, pop;
  logic [1:0]  addr;
  logic [15:0] wdata, rdata;
  logic [47:0] dout;

  render_queue #(.DEPTH(DEPTH), .CW(5)) dut (
    .clk50(clk50), .reset(reset), .chipselect(cs), .write(wr), .read(rd),
    .address(addr), .writedata(wdata), .readdata(rdata),
    .render_queue_dout(dout), .render_queue_pop_front(pop)
  );

  always #5 clk50 = ~clk50;

  int          n_tests = 0, n_fail = 0;
  logic [47:0] sb [$];
  logic        m_ovf;
  logic [7:0]  s_magic, s_flags;
  logic [15:0] s_x;

  task automatic tick; @(posedge clk50); #1; endtask

  function automatic logic [15:0] exp_status();
    int n = sb.size();
    logic [4:0] c = n[4:0];
    return {8'h00, m_ovf, (n == 0), (n == DEPTH), c};
  endfunction

  task automatic clr_model;
    sb.delete(); m_ovf = 1'b0; s_magic = '0; s_flags = '0; s_x = '0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick;
    cs = 1'b0; wr = 1'b0;
    case (a)
      2'd0: begin s_magic = d[15:8]; s_flags = d[7:0]; end
      2'd1: s_x = d;
      2'd2: if (sb.size() < DEPTH) sb.push_back({s_magic, s_x, d, s_flags});
            else m_ovf = 1'b1;
      2'd3: m_ovf = 1'b0;
    endcase
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick;
    cs = 1'b0; rd = 1'b0;
    v = rdata;
  endtask

  task automatic do_pop;
    pop = 1'b1;
    tick;
    pop = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset = 1'b1; tick; tick; reset = 1'b0;
    clr_model;
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL reset_dout got %h want %h", dout, SENT); end
    n_tests++;
    if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0040) begin n_fail++; $display("FAIL reset_status got %h want 0040", v); end
  endtask

  task automatic test_basic;
    logic [15:0] v;
    bus_wr(2'd0, 16'h0301); bus_wr(2'd1, 16'd320); bus_wr(2'd2, 16'd240);
    n_tests++;
    if (dout !== 48'h03_0140_00F0_01) begin n_fail++; $display("FAIL basic_dout got %h want 03014000f001", dout); end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL basic_status got %h want 0001", v); end
    tick;
    n_tests++;
    if (rdata !== 16'h0) begin n_fail++; $display("FAIL basic_idle_rdata got %h want 0", rdata); end
    bus_rd(2'd1, v);
    n_tests++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL basic_rd_addr1 got %h want 0", v); end
    // Second push re-uses staged magic/x/flags with a new y.
    bus_wr(2'd2, 16'd100);
    n_tests++;
    if (dout !== sb[0]) begin n_fail++; $display("FAIL basic_head got %h want %h", dout, sb[0]); end
    do_pop;
    n_tests++;
    if (dout !== 48'h03_0140_0064_01) begin n_fail++; $display("FAIL basic_restage got %h want 030140006401", dout); end
    do_pop;
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL basic_drain got %h want %h", dout, SENT); end
  endtask

  task automatic test_order_wrap;
    logic [15:0] v;
    bus_wr(2'd0, 16'hA53C);
    for (int i = 0; i < 40; i++) begin
      bus_wr(2'd1, 16'(i * 3));
      bus_wr(2'd2, 16'(16'h1000 + i));
      if (i >= 10) begin
        n_tests++;
        if (dout !== sb[0]) begin n_fail++; $display("FAIL wrap_pop%0d got %h want %h", i, dout, sb[0]); end
        do_pop;
      end
    end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h000A) begin n_fail++; $display("FAIL wrap_count got %h want 000a", v); end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (dout !== sb[0]) begin n_fail++; $display("FAIL wrap_drain%0d got %h want %h", i, dout, sb[0]); end
      do_pop;
    end
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL wrap_empty got %h want %h", dout, SENT); end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    bus_wr(2'd0, 16'h7E42);
    for (int i = 0; i < 26; i++) begin
      bus_wr(2'd1, 16'(i));
      bus_wr(2'd2, 16'(500 + i));
    end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h00B9 || v !== exp_status()) begin n_fail++; $display("FAIL ovf_status got %h want 00b9", v); end
    n_tests++;
    if (dout !== {8'h7E, 16'd0, 16'd500, 8'h42}) begin n_fail++; $display("FAIL ovf_head got %h want first entry", dout); end
    bus_wr(2'd3, 16'h0);
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0039) begin n_fail++; $display("FAIL ovf_clear got %h want 0039", v); end
  endtask

  task automatic test_full_edge;
    logic [15:0] v;
    logic [47:0] h1;
    h1 = sb[1];
    cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 16'hBEEF; pop = 1'b1;
    tick;
    cs = 1'b0; wr = 1'b0; pop = 1'b0;
    void'(sb.pop_front());
    sb.push_back({s_magic, s_x, 16'hBEEF, s_flags});
    n_tests++;
    if (dout !== h1) begin n_fail++; $display("FAIL full_head got %h want %h", dout, h1); end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0039) begin n_fail++; $display("FAIL full_status got %h want 0039", v); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (dout !== sb[0]) begin n_fail++; $display("FAIL full_drain%0d got %h want %h", i, dout, sb[0]); end
      do_pop;
    end
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL full_empty got %h want %h", dout, SENT); end
  endtask

  task automatic test_empty_edge;
    logic [15:0] v;
    do_pop;
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL empty_pop got %h want %h", dout, SENT); end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0040) begin n_fail++; $display("FAIL empty_status got %h want 0040", v); end
    cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 16'h0055; pop = 1'b1;
    tick;
    cs = 1'b0; wr = 1'b0; pop = 1'b0;
    sb.push_back({s_magic, s_x, 16'h0055, s_flags});
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL empty_pushpop got %h want 0001", v); end
    n_tests++;
    if (dout !== sb[0]) begin n_fail++; $display("FAIL empty_pushpop_dout got %h want %h", dout, sb[0]); end
    do_pop;
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    bus_wr(2'd0, 16'h1122); bus_wr(2'd1, 16'h3344);
    for (int i = 0; i < 5; i++) bus_wr(2'd2, 16'(i));
    // Requests during reset must be ignored.
    reset = 1'b1; cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 16'hDEAD; pop = 1'b1;
    tick;
    reset = 1'b0; cs = 1'b0; wr = 1'b0; pop = 1'b0;
    clr_model;
    n_tests++;
    if (dout !== SENT) begin n_fail++; $display("FAIL rstmid_dout got %h want %h", dout, SENT); end
    bus_rd(2'd3, v);
    n_tests++;
    if (v !== 16'h0040) begin n_fail++; $display("FAIL rstmid_status got %h want 0040", v); end
    bus_wr(2'd2, 16'h0007);
    n_tests++;
    if (dout !== 48'h00_0000_0007_00) begin n_fail++; $display("FAIL rstmid_staged got %h want 000000000700", dout); end
    do_pop;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; pop = 1'b0;
    addr = '0; wdata = '0;
    clr_model;
    test_reset;
    test_basic;
    test_order_wrap;
    test_overflow;
    test_full_edge;
    test_empty_edge;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
